// File: rtl/dump_pkg.sv
// ----------------------------------------------------------------------------
// dump_pkg
//
// Shared definitions for the halt register-dump transmitter.
//   DUMP_DATA_W : default register / stream word width
//   DUMP_NREGS  : default number of CPU registers in a dump (A..H)
//   DUMP_HDR    : default frame header word (zero-extended by the user)
//   dump_state_t: frame sequencer states
// ----------------------------------------------------------------------------
package dump_pkg;

    localparam int         DUMP_DATA_W = 8;
    localparam int         DUMP_NREGS  = 8;
    localparam logic [7:0] DUMP_HDR    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        REGS,
        CSUM,
        REARM
    } dump_state_t;

endpackage

// File: rtl/halt_dump_tx.sv
// ----------------------------------------------------------------------------
// halt_dump_tx
//
// On a rising edge of the CPU halt flag, captures a snapshot of all CPU
// registers and streams a frame out over a valid/ready interface:
//   header word, register A .. last register, XOR checksum of the registers.
// After the frame the block waits for the halt flag to drop before it can be
// triggered again, so one halt produces exactly one frame.
//
// Ports
//   clk        : single clock, rising-edge active
//   reset      : synchronous, active-low reset
//   cpu_halted : CPU halt flag (level)
//   regs_flat  : live CPU registers, reg A in the lowest DATA_W bits
//   tx_data    : current stream word
//   tx_valid   : tx_data is valid
//   tx_ready   : consumer accepts the word (transfer = tx_valid && tx_ready)
//   dump_busy  : a frame is in progress
//   dump_done  : one-cycle pulse after the checksum word is transferred
//   dump_count : number of completed frames, wraps at 256
// ----------------------------------------------------------------------------
module halt_dump_tx
    import dump_pkg::*;
#(
    parameter int                DATA_W = DUMP_DATA_W,
    parameter int                NREGS  = DUMP_NREGS,
    parameter logic [DATA_W-1:0] HDR    = DATA_W'(DUMP_HDR)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_halted,
    input  logic [NREGS*DATA_W-1:0] regs_flat,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    dump_busy,
    output logic                    dump_done,
    output logic [7:0]              dump_count
);

    localparam int               IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    dump_state_t       state;
    dump_state_t       next_state;
    logic              halted_q;
    logic              halt_edge;
    logic [DATA_W-1:0] snapshot [NREGS];
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] csum;

    assign halt_edge = cpu_halted && !halted_q;

    // Delayed copy of the halt flag for edge detection. It comes out of reset
    // as 1 so that a CPU already halted while reset is held does not look
    // like a fresh halt; only a genuine 0->1 transition starts a dump.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halted_q <= 1'b1;
        end else begin
            halted_q <= cpu_halted;
        end
    end

    // Register snapshot taken in the same cycle the halt edge is accepted.
    // The frame is built only from this copy, so later activity on the live
    // registers cannot leak into a frame in progress.
    always_ff @(posedge clk) begin
        if (state == IDLE && halt_edge) begin
            for (int i = 0; i < NREGS; i++) begin
                snapshot[i] <= regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Checksum is a plain XOR over the snapshot; the header is not included.
    always_comb begin
        csum = '0;
        for (int i = 0; i < NREGS; i++) begin
            csum = csum ^ snapshot[i];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Every streaming state advances only on an accepted
    // word, so a stalled consumer simply freezes the sequencer. Halt edges
    // seen outside IDLE are dropped; REARM waits for the halt flag to clear
    // so a halt held high after the frame does not retrigger.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (halt_edge) begin
                    next_state = HEADER;
                end
            end
            HEADER: begin
                if (tx_ready) begin
                    next_state = REGS;
                end
            end
            REGS: begin
                if (tx_ready && idx == LAST_IDX) begin
                    next_state = CSUM;
                end
            end
            CSUM: begin
                if (tx_ready) begin
                    next_state = REARM;
                end
            end
            REARM: begin
                if (!cpu_halted) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. The stream word is a pure function of state, index and
    // snapshot, which keeps it stable for as long as the consumer stalls.
    always_comb begin
        tx_valid  = 1'b0;
        dump_busy = 1'b0;
        tx_data   = '0;
        case (state)
            HEADER: begin
                tx_valid  = 1'b1;
                dump_busy = 1'b1;
                tx_data   = HDR;
            end
            REGS: begin
                tx_valid  = 1'b1;
                dump_busy = 1'b1;
                tx_data   = snapshot[idx];
            end
            CSUM: begin
                tx_valid  = 1'b1;
                dump_busy = 1'b1;
                tx_data   = csum;
            end
            default: begin
                tx_valid  = 1'b0;
                dump_busy = 1'b0;
                tx_data   = '0;
            end
        endcase
    end

    // Register index walker: cleared when the header goes out, stepped on
    // every accepted register word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx <= '0;
        end else if (state == HEADER && tx_ready) begin
            idx <= '0;
        end else if (state == REGS && tx_ready) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    // Frame completion: pulse done and bump the frame counter when the
    // checksum word is accepted. A reset mid-frame never reaches this point,
    // so an aborted frame is neither flagged nor counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dump_done  <= 1'b0;
            dump_count <= 8'd0;
        end else begin
            dump_done <= (state == CSUM) && tx_ready;
            if (state == CSUM && tx_ready) begin
                dump_count <= dump_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_halt_dump_tx.sv
// ----------------------------------------------------------------------------
// tb_halt_dump_tx
//
// Self-checking bench for halt_dump_tx. A monitor records every accepted
// stream word, dump_done pulses, busy cycles and any change of tx_data while
// stalled. Expected frames are built from the register values the bench
// applied: header, registers A upward, then their XOR.
// ----------------------------------------------------------------------------
module tb_halt_dump_tx;

    localparam int         DATA_W = 8;
    localparam int         NREGS  = 8;
    localparam logic [7:0] HDR    = 8'hA5;
    localparam int         BUDGET = 400;

    logic                    clk;
    logic                    reset;
    logic                    cpu_halted;
    logic [NREGS*DATA_W-1:0] regs_flat;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    dump_busy;
    logic                    dump_done;
    logic [7:0]              dump_count;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          pat = 0;
    int          done_pulses = 0;
    int          last_done_cyc = 0;
    int          busy_cycles = 0;
    int          stall_viol = 0;
    int          model_count = 0;
    int          start_cyc = 0;
    bit          timed_out = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    halt_dump_tx #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .HDR   (HDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_halted(cpu_halted),
        .regs_flat (regs_flat),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dump_busy (dump_busy),
        .dump_done (dump_done),
        .dump_count(dump_count)
    );

    // Free-running clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, a 1,0,0,1 repeating pattern, or random.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: begin
                    tx_ready = (pat == 0 || pat == 3);
                    pat = (pat + 1) % 4;
                end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor sampled mid-cycle: records transfers, done pulses, busy cycles
    // and any stall where the offered word changed or vanished.
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) got_q.push_back(tx_data);
        if (dump_done) begin
            done_pulses++;
            last_done_cyc = cyc;
        end
        if (dump_busy) busy_cycles++;
        if (prev_stall && reset && (!tx_valid || tx_data !== prev_data)) stall_viol++;
        prev_stall = reset && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, each register in order, XOR of registers.
    function automatic void model_frame(input logic [NREGS*DATA_W-1:0] r);
        logic [7:0] x;
        x = '0;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int i = 0; i < NREGS; i++) begin
            exp_q.push_back(r[i*DATA_W +: DATA_W]);
            x = x ^ r[i*DATA_W +: DATA_W];
        end
        exp_q.push_back(x);
    endfunction

    // -2 on length difference, index of first differing word, -1 if equal.
    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [NREGS*DATA_W-1:0] rand_regs();
        return {$urandom, $urandom};
    endfunction

    // Drives one complete halt sequence: drop halt, rearm, raise halt, and
    // optionally overwrite the live registers one cycle later.
    task automatic applyStimulus(input logic [NREGS*DATA_W-1:0] r, input int mode, input bit corrupt);
        int d0;
        regs_flat  = r;
        cpu_halted = 1'b0;
        ready_mode = mode;
        tick();
        tick();
        got_q.delete();
        busy_cycles = 0;
        stall_viol  = 0;
        d0 = done_pulses;
        timed_out = 0;
        cpu_halted = 1'b1;
        start_cyc = cyc;
        if (corrupt) begin
            tick();
            regs_flat = '1;
        end
        for (int k = 0; k < BUDGET && done_pulses == d0; k++) tick();
        if (done_pulses == d0) timed_out = 1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_halted = 1'b1;
        regs_flat = rand_regs();
        ready_mode = 0;
        tick();
        tick();
        tick();
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tx_data got %h exp 00", tx_data); end
        checks++; if (dump_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b exp 0", dump_busy); end
        checks++; if (dump_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b exp 0", dump_done); end
        checks++; if (dump_count !== 8'd0) begin fails++; $display("[TB] FAIL reset_count got %0d exp 0", dump_count); end
        got_q.delete();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (got_q.size() !== 0) begin fails++; $display("[TB] FAIL held_halt_no_frame got %0d words exp 0", got_q.size()); end
        checks++; if (done_pulses !== 0) begin fails++; $display("[TB] FAIL held_halt_no_done got %0d exp 0", done_pulses); end
        model_count = 0;
    endtask

    task automatic test_reset_mid_frame();
        logic [NREGS*DATA_W-1:0] r;
        int d0;
        r = rand_regs();
        regs_flat = r;
        cpu_halted = 1'b0;
        ready_mode = 0;
        tick();
        tick();
        got_q.delete();
        d0 = done_pulses;
        cpu_halted = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (got_q.size() !== 4) begin fails++; $display("[TB] FAIL mid_words_before_reset got %0d exp 4", got_q.size()); end
        reset = 1'b0;
        tick();
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_valid got %b exp 0", tx_valid); end
        checks++; if (dump_busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_busy got %b exp 0", dump_busy); end
        reset = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (done_pulses !== d0) begin fails++; $display("[TB] FAIL mid_reset_no_done got %0d exp %0d", done_pulses, d0); end
        checks++; if (dump_count !== 8'(model_count)) begin fails++; $display("[TB] FAIL mid_reset_count got %0d exp %0d", dump_count, 8'(model_count)); end
        checks++; if (got_q.size() !== 4) begin fails++; $display("[TB] FAIL mid_reset_no_new_frame got %0d exp 4", got_q.size()); end
    endtask

    task automatic test_basic_frame();
        logic [NREGS*DATA_W-1:0] r;
        int d0, diff;
        for (int i = 0; i < NREGS; i++) r[i*DATA_W +: DATA_W] = 8'(i + 1);
        model_frame(r);
        d0 = done_pulses;
        applyStimulus(r, 0, 0);
        model_count++;
        diff = first_diff();
        checks++; if (timed_out !== 0) begin fails++; $display("[TB] FAIL basic_timeout got %0d exp 0", timed_out); end
        checks++; if (diff !== -1) begin fails++; $display("[TB] FAIL basic_stream got %0d words exp %0d, first bad index %0d", got_q.size(), exp_q.size(), diff); end
        checks++; if (got_q.size() == 10 && got_q[9] !== 8'h08) begin fails++; $display("[TB] FAIL basic_checksum got %h exp 08", got_q[9]); end
        checks++; if (last_done_cyc - start_cyc !== NREGS + 3) begin fails++; $display("[TB] FAIL basic_latency got %0d exp %0d", last_done_cyc - start_cyc, NREGS + 3); end
        checks++; if (done_pulses - d0 !== 1) begin fails++; $display("[TB] FAIL basic_done_pulse got %0d cycles exp 1", done_pulses - d0); end
        checks++; if (busy_cycles !== NREGS + 2) begin fails++; $display("[TB] FAIL basic_busy got %0d exp %0d", busy_cycles, NREGS + 2); end
        checks++; if (dump_count !== 8'(model_count)) begin fails++; $display("[TB] FAIL basic_count got %0d exp %0d", dump_count, 8'(model_count)); end
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_rearm_valid got %b exp 0", tx_valid); end
    endtask

    task automatic test_stall();
        logic [NREGS*DATA_W-1:0] r;
        int diff;
        for (int i = 0; i < NREGS; i++) r[i*DATA_W +: DATA_W] = 8'(i + 1);
        model_frame(r);
        pat = 0;
        applyStimulus(r, 1, 0);
        model_count++;
        diff = first_diff();
        checks++; if (timed_out !== 0) begin fails++; $display("[TB] FAIL stall_timeout got %0d exp 0", timed_out); end
        checks++; if (diff !== -1) begin fails++; $display("[TB] FAIL stall_stream got %0d words exp %0d, first bad index %0d", got_q.size(), exp_q.size(), diff); end
        checks++; if (stall_viol !== 0) begin fails++; $display("[TB] FAIL stall_hold got %0d unstable stalls exp 0", stall_viol); end
        checks++; if (dump_count !== 8'(model_count)) begin fails++; $display("[TB] FAIL stall_count got %0d exp %0d", dump_count, 8'(model_count)); end
    endtask

    task automatic test_snapshot();
        logic [NREGS*DATA_W-1:0] r;
        int diff;
        for (int i = 0; i < NREGS; i++) r[i*DATA_W +: DATA_W] = 8'(i + 1);
        model_frame(r);
        applyStimulus(r, 0, 1);
        model_count++;
        diff = first_diff();
        checks++; if (diff !== -1) begin fails++; $display("[TB] FAIL snapshot_stream got %0d words exp %0d, first bad index %0d", got_q.size(), exp_q.size(), diff); end
        checks++; if (got_q.size() == 10 && got_q[9] !== 8'h08) begin fails++; $display("[TB] FAIL snapshot_checksum got %h exp 08", got_q[9]); end
    endtask

    task automatic test_second_edge();
        logic [NREGS*DATA_W-1:0] r;
        int d0, diff;
        r = rand_regs();
        model_frame(r);
        regs_flat = r;
        cpu_halted = 1'b0;
        ready_mode = 0;
        tick();
        tick();
        got_q.delete();
        d0 = done_pulses;
        cpu_halted = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        cpu_halted = 1'b0;
        tick();
        cpu_halted = 1'b1;
        for (int k = 0; k < BUDGET && done_pulses == d0; k++) tick();
        for (int k = 0; k < 30; k++) tick();
        model_count++;
        diff = first_diff();
        checks++; if (diff !== -1) begin fails++; $display("[TB] FAIL second_edge_stream got %0d words exp %0d, first bad index %0d", got_q.size(), exp_q.size(), diff); end
        checks++; if (done_pulses - d0 !== 1) begin fails++; $display("[TB] FAIL second_edge_one_frame got %0d done cycles exp 1", done_pulses - d0); end
        checks++; if (dump_count !== 8'(model_count)) begin fails++; $display("[TB] FAIL second_edge_count got %0d exp %0d", dump_count, 8'(model_count)); end
        r = rand_regs();
        model_frame(r);
        applyStimulus(r, 0, 0);
        model_count++;
        diff = first_diff();
        checks++; if (diff !== -1) begin fails++; $display("[TB] FAIL rearm_new_frame got %0d words exp %0d, first bad index %0d", got_q.size(), exp_q.size(), diff); end
        checks++; if (dump_count !== 8'(model_count)) begin fails++; $display("[TB] FAIL rearm_count got %0d exp %0d", dump_count, 8'(model_count)); end
    endtask

    task automatic test_random();
        int bad, diff;
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            logic [NREGS*DATA_W-1:0] r;
            r = rand_regs();
            model_frame(r);
            applyStimulus(r, 2, n[0]);
            model_count++;
            diff = first_diff();
            if (diff !== -1 || timed_out || stall_viol != 0) begin
                bad++;
                $display("[TB] frame %0d differs: %0d words vs %0d, index %0d", n, got_q.size(), exp_q.size(), diff);
            end
        end
        checks++; if (bad !== 0) begin fails++; $display("[TB] FAIL random_frames got %0d bad frames exp 0", bad); end
        checks++; if (dump_count !== 8'(model_count)) begin fails++; $display("[TB] FAIL random_count got %0d exp %0d", dump_count, 8'(model_count)); end
    endtask

    task automatic test_wrap();
        int n, bad;
        bad = 0;
        n = 256 - (model_count % 256);
        for (int k = 0; k < n - 1; k++) begin
            logic [NREGS*DATA_W-1:0] r;
            r = rand_regs();
            model_frame(r);
            applyStimulus(r, 0, 0);
            model_count++;
            if (first_diff() !== -1 || timed_out) bad++;
        end
        checks++; if (dump_count !== 8'd255) begin fails++; $display("[TB] FAIL wrap_255 got %0d exp 255", dump_count); end
        model_frame(regs_flat);
        applyStimulus(regs_flat, 0, 0);
        model_count++;
        if (first_diff() !== -1 || timed_out) bad++;
        checks++; if (dump_count !== 8'd0) begin fails++; $display("[TB] FAIL wrap_0 got %0d exp 0", dump_count); end
        checks++; if (bad !== 0) begin fails++; $display("[TB] FAIL wrap_frames got %0d bad frames exp 0", bad); end
    endtask

    initial begin
        $display("[TB] halt_dump_tx bench start");
        test_reset();
        test_reset_mid_frame();
        test_basic_frame();
        test_stall();
        test_snapshot();
        test_second_edge();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
